centering_unit: RTL

//  Responder to the whitening sequencer's centering commands (GO_cen / sample strobes).
//  Two passes over one sample block of N_CH channels:
//   - Pass 1 accumulates per-channel sums and forms the mean.
//   - Pass 2 streams centered samples (x - mean) towards the covariance stage and mem2.

---
 rtl/centering_unit_pkg.sv | 16 +
 rtl/cen_lane.sv | 83 ++++++++
 rtl/centering_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/centering_unit_pkg.sv
// rtl/centering_unit_pkg.sv - shared defaults and FSM state encoding for the centering unit
package centering_unit_pkg;

    localparam int CEN_DATA_W = 32;
    localparam int CEN_N_CH   = 2;
    localparam int CEN_LOG2_N = 7;

    typedef enum logic [2:0] {
        CEN_IDLE = 3'd0,
        CEN_SUM  = 3'd1,
        CEN_DIV  = 3'd2,
        CEN_SUB  = 3'd3,
        CEN_DONE = 3'd4
    } cen_state_t;

endpackage

// File: rtl/cen_lane.sv
// rtl/cen_lane.sv - per-channel accumulator, mean register and centered-sample register
// Saturating subtraction and sticky flag present only when CEN_SAT_EN is defined.
module cen_lane
    import centering_unit_pkg::*;
#(
    parameter int DATA_W = CEN_DATA_W,
    parameter int LOG2_N = CEN_LOG2_N
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              acc_en,
    input  logic              div_en,
    input  logic              sub_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] mean,
    output logic [DATA_W-1:0] dout,
    output logic              sat
);

    localparam int ACC_W = DATA_W + LOG2_N;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]       mean_q, mean_d;
    logic [DATA_W-1:0]       dout_q, dout_d;
    logic [DATA_W-1:0]       res;

`ifdef CEN_SAT_EN
    logic signed [DATA_W:0]  diff;
    logic                    ovf;
    logic                    sat_q, sat_d;
`endif

    always_comb begin
`ifdef CEN_SAT_EN
        diff = $signed({din[DATA_W-1], din}) - $signed({mean_q[DATA_W-1], mean_q});
        ovf  = diff[DATA_W] ^ diff[DATA_W-1];
        // Clamp toward the true sign held in the extra top bit
        res  = ovf ? {diff[DATA_W], {(DATA_W-1){~diff[DATA_W]}}} : diff[DATA_W-1:0];
        sat_d = clr ? 1'b0 : (sat_q | (sub_en & ovf));
`else
        res  = din - mean_q;
`endif
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + $signed({{LOG2_N{din[DATA_W-1]}}, din});
        end
        // Arithmetic shift by LOG2_N then truncation is exactly this bit window
        mean_d = div_en ? acc_q[LOG2_N +: DATA_W] : mean_q;
        dout_d = sub_en ? res : dout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            mean_q <= '0;
            dout_q <= '0;
        end else begin
            acc_q  <= acc_d;
            mean_q <= mean_d;
            dout_q <= dout_d;
        end
    end

`ifdef CEN_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end
    assign sat = sat_q;
`else
    assign sat = 1'b0;
`endif

    assign mean = mean_q;
    assign dout = dout_q;

endmodule

// File: rtl/centering_unit.sv
// rtl/centering_unit.sv - two-pass mean removal (sum, divide, subtract) for the whitening sequencer
// Optional saturation of centered samples via macro CEN_SAT_EN (see cen_lane).
module centering_unit
    import centering_unit_pkg::*;
#(
    parameter int DATA_W = CEN_DATA_W,
    parameter int N_CH   = CEN_N_CH,
    parameter int LOG2_N = CEN_LOG2_N
) (
    input  logic                   CLK_cen,
    input  logic                   nRST_cen,
    input  logic                   GO_cen,
    input  logic                   Din_valid,
    input  logic [N_CH*DATA_W-1:0] Din,
    output logic [N_CH*DATA_W-1:0] Dout,
    output logic                   Dout_valid,
    output logic [N_CH*DATA_W-1:0] Mean_out,
    output logic                   CEN_busy,
    output logic                   Sat_flag
);

    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

    cen_state_t        state_q, state_d;
    logic [LOG2_N-1:0] count_q, count_d;
    logic              busy_q, busy_d;
    logic              dout_valid_q, dout_valid_d;
    logic              clr, acc_en, div_en, sub_en;
    logic [N_CH-1:0]   lane_sat;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        dout_valid_d = 1'b0;
        clr          = 1'b0;
        acc_en       = 1'b0;
        div_en       = 1'b0;
        sub_en       = 1'b0;
        if (!GO_cen) begin
            // Abort dominates any sample presented in the same cycle
            state_d = CEN_IDLE;
            count_d = '0;
            clr     = 1'b1;
        end else begin
            case (state_q)
                CEN_IDLE: begin
                    clr     = 1'b1;
                    count_d = '0;
                    state_d = CEN_SUM;
                end
                CEN_SUM: begin
                    if (Din_valid) begin
                        acc_en  = 1'b1;
                        count_d = count_q + LOG2_N'(1);
                        if (count_q == CNT_LAST) state_d = CEN_DIV;
                    end
                end
                CEN_DIV: begin
                    div_en  = 1'b1;
                    state_d = CEN_SUB;
                end
                CEN_SUB: begin
                    if (Din_valid) begin
                        sub_en       = 1'b1;
                        dout_valid_d = 1'b1;
                        count_d      = count_q + LOG2_N'(1);
                        if (count_q == CNT_LAST) state_d = CEN_DONE;
                    end
                end
                CEN_DONE: begin
                    state_d = CEN_DONE;
                end
                default: begin
                    state_d = CEN_IDLE;
                    count_d = '0;
                    clr     = 1'b1;
                end
            endcase
        end
        busy_d = (state_d == CEN_SUM) || (state_d == CEN_DIV) || (state_d == CEN_SUB);
    end

    always_ff @(posedge CLK_cen or negedge nRST_cen) begin
        if (!nRST_cen) begin
            state_q      <= CEN_IDLE;
            count_q      <= '0;
            busy_q       <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        cen_lane #(
            .DATA_W (DATA_W),
            .LOG2_N (LOG2_N)
        ) u_lane (
            .clk    (CLK_cen),
            .rst_n  (nRST_cen),
            .clr    (clr),
            .acc_en (acc_en),
            .div_en (div_en),
            .sub_en (sub_en),
            .din    (Din[c*DATA_W +: DATA_W]),
            .mean   (Mean_out[c*DATA_W +: DATA_W]),
            .dout   (Dout[c*DATA_W +: DATA_W]),
            .sat    (lane_sat[c])
        );
    end

    assign Dout_valid = dout_valid_q;
    assign CEN_busy   = busy_q;
    assign Sat_flag   = |lane_sat;

endmodule
